// File: rtl/wb_stage_multi_pkg.sv
// Shared widths, stall-bus bit positions and lane record layouts for the writeback stage.
// No logic; types and constants only.
// Not applicable: holds no state and applies no backpressure.
package wb_stage_multi_pkg;

    localparam int WB_LANE_WD  = 73;
    localparam int RF_LANE_WD  = 41;
    localparam int STALL_WD    = 6;
    localparam int STALL_WB_IN = 4;
    localparam int STALL_DOWN  = 5;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // One retiring instruction as it arrives from MEM and as it is traced.
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wstrb;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_lane_t;

    // One register-file write port.
    typedef struct packed {
        logic [3:0]  wstrb;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_lane_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular trace buffer: pushes up to LANES entries per cycle, pops one per cycle.
// Push is written at the clock edge; an entry is poppable from the following cycle.
// No internal backpressure; the parent must keep count + push_cnt within DEPTH.
module wb_trace_fifo
    import wb_stage_multi_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
)(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [LANES-1:0]     push_vld,
    input  wb_lane_t [LANES-1:0] push_dat,
    output logic [CW-1:0]        push_cnt,
    output logic                 pop_vld,
    output wb_lane_t             pop_dat,
    output logic [CW-1:0]        count
);

    localparam logic [CW-1:0] PTR_MASK = CW'(DEPTH - 1);

    wb_lane_t      mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [PW-1:0] slot [LANES];

    // Pack the writing lanes into consecutive slots, preserving lane order.
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wr_ptr[PW-1:0] + acc[PW-1:0];
            acc     = acc + CW'(push_vld[i]);
        end
        push_cnt = acc;
    end

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr[PW-1:0]];

    // Storage array; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_vld[i]) mem[slot[i]] <= push_dat[i];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= (wr_ptr + push_cnt) & PTR_MASK;
            rd_ptr <= (rd_ptr + CW'(pop_vld)) & PTR_MASK;
            count  <= count + push_cnt - CW'(pop_vld);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!resetn)
        (int'(count) + int'(push_cnt) - int'(pop_vld)) <= DEPTH);

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback: latches a retiring bundle, drives RF writes, serialises a debug trace.
// RF writes one cycle after MEM (combinational from bund_r); debug commit from a registered FIFO pop.
// Raises wb_stallreq when the trace FIFO could not take another full bundle.
module wb_stage_multi
    import wb_stage_multi_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DBG_DEPTH = 8
)(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [STALL_WD-1:0]         stall,
    input  logic [LANES*WB_LANE_WD-1:0] mem_to_wb_bus,
    output logic [LANES*RF_LANE_WD-1:0] wb_to_rf_bus,
    output logic                        wb_stallreq,
    output logic [31:0]                 debug_wb_pc,
    output logic [3:0]                  debug_wb_rf_wen,
    output logic [4:0]                  debug_wb_rf_wnum,
    output logic [31:0]                 debug_wb_rf_wdata
);

    localparam int CW = $clog2(DBG_DEPTH) + 1;

    wb_lane_t [LANES-1:0] bund_r;
    rf_lane_t [LANES-1:0] rf_lanes;
    logic     [LANES-1:0] lane_wr;
    logic     [LANES-1:0] lane_kill;
    logic     [CW-1:0]    push_cnt;
    logic     [CW-1:0]    trace_count;
    logic                 pop_vld;
    wb_lane_t             pop_dat;
    logic                 unused_stall;

    assign unused_stall = ^stall[3:0];

    // Bundle register: bubble when only WB input is stopped, load when free, else hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bund_r <= '0;
        end else if (stall[STALL_WB_IN] == Stop && stall[STALL_DOWN] == NoStop) begin
            bund_r <= '0;
        end else if (stall[STALL_WB_IN] == NoStop) begin
            bund_r <= mem_to_wb_bus;
        end
    end

    // RF ports: an older lane loses its write when a younger lane targets the same nonzero register.
    always_comb begin
        lane_wr   = '0;
        lane_kill = '0;
        rf_lanes  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_wr[i] = (bund_r[i].wstrb != 4'd0);
            for (int j = i + 1; j < LANES; j++) begin
                if (bund_r[j].wstrb != 4'd0 && bund_r[i].waddr != 5'd0 &&
                    bund_r[j].waddr == bund_r[i].waddr) begin
                    lane_kill[i] = 1'b1;
                end
            end
            rf_lanes[i].wstrb = lane_kill[i] ? 4'd0 : bund_r[i].wstrb;
            rf_lanes[i].waddr = bund_r[i].waddr;
            rf_lanes[i].wdata = bund_r[i].wdata;
        end
    end

    assign wb_to_rf_bus = rf_lanes;

    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (DBG_DEPTH)
    ) u_trace (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (lane_wr),
        .push_dat (bund_r),
        .push_cnt (push_cnt),
        .pop_vld  (pop_vld),
        .pop_dat  (pop_dat),
        .count    (trace_count)
    );

    // Room must remain for one more full bundle after this cycle's pushes.
    assign wb_stallreq = (DBG_DEPTH - int'(trace_count) - int'(push_cnt)) < LANES;

    // Debug commit port: load on pop, otherwise drop wen and keep the last entry visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else if (pop_vld) begin
            debug_wb_pc       <= pop_dat.pc;
            debug_wb_rf_wen   <= pop_dat.wstrb;
            debug_wb_rf_wnum  <= pop_dat.waddr;
            debug_wb_rf_wdata <= pop_dat.wdata;
        end else begin
            debug_wb_rf_wen   <= '0;
        end
    end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi (LANES=2, DBG_DEPTH=8).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// The bench acts as the stall controller in the back-pressure scenario.
module tb_wb_stage_multi;

    logic         clk;
    logic         resetn;
    logic [5:0]   stall;
    logic [145:0] mem_to_wb_bus;
    logic [81:0]  wb_to_rf_bus;
    logic         wb_stallreq;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic [72:0] exp_q [$];

    wb_stage_multi #(.LANES(2), .DBG_DEPTH(8)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .stall             (stall),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .wb_stallreq       (wb_stallreq),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [72:0] ln(input logic [31:0] pc, input logic [3:0] ws,
                                       input logic [4:0] wa, input logic [31:0] wd);
        return {pc, ws, wa, wd};
    endfunction

    // Every commit on the debug port must match the next expected trace entry.
    task automatic mon();
        logic [72:0] e;
        if (debug_wb_rf_wen != 4'd0) begin
            if (exp_q.size() == 0) begin
                chk("trace_extra", {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("trace", {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        chk(tag, exp_q.size(), 0);
    endtask

    logic [72:0] a0, a1, b0, b1, nb, xx, yy, zz;
    int idx, first_req, req_cycles;

    initial begin
        resetn = 1'b0;
        stall = 6'b0;
        mem_to_wb_bus = '0;
        #1;
        chk("rst_rf", wb_to_rf_bus, 0);
        chk("rst_req", wb_stallreq, 0);
        chk("rst_pc", debug_wb_pc, 0);
        chk("rst_wen", debug_wb_rf_wen, 0);
        chk("rst_wnum", debug_wb_rf_wnum, 0);
        chk("rst_wdata", debug_wb_rf_wdata, 0);
        step();
        step();
        resetn = 1'b1;

        // Single lane on lane 0
        a0 = ln(32'hBFC00000, 4'hF, 5'd3, 32'h1234);
        mem_to_wb_bus = {73'd0, a0};
        exp_q.push_back(a0);
        step();
        chk("single_rf0", wb_to_rf_bus[40:0], a0[40:0]);
        chk("single_rf1", wb_to_rf_bus[81:41], 0);
        mem_to_wb_bus = '0;
        drain("single_drain", 6);
        step();
        chk("idle_wen", debug_wb_rf_wen, 0);
        chk("idle_pc_hold", debug_wb_pc, 32'hBFC00000);
        chk("idle_wnum_hold", debug_wb_rf_wnum, 5'd3);

        // Same-address conflict: younger lane wins on RF, both traced
        a0 = ln(32'h000000FC, 4'hF, 5'd5, 32'hAAAA);
        a1 = ln(32'h00000100, 4'hF, 5'd5, 32'hBBBB);
        mem_to_wb_bus = {a1, a0};
        exp_q.push_back(a0);
        exp_q.push_back(a1);
        step();
        chk("conf_rf0", wb_to_rf_bus[40:0], {4'h0, 5'd5, 32'hAAAA});
        chk("conf_rf1", wb_to_rf_bus[81:41], {4'hF, 5'd5, 32'hBBBB});
        // Both lanes on r0: no suppression
        a0 = ln(32'h00000104, 4'hF, 5'd0, 32'h1);
        a1 = ln(32'h00000108, 4'hF, 5'd0, 32'h2);
        mem_to_wb_bus = {a1, a0};
        exp_q.push_back(a0);
        exp_q.push_back(a1);
        step();
        chk("r0_rf0", wb_to_rf_bus[40:0], {4'hF, 5'd0, 32'h1});
        chk("r0_rf1", wb_to_rf_bus[81:41], {4'hF, 5'd0, 32'h2});
        mem_to_wb_bus = '0;
        drain("conf_drain", 10);

        // Bubble then hold
        xx = ln(32'h00000200, 4'hF, 5'd7, 32'h77);
        mem_to_wb_bus = {73'd0, xx};
        exp_q.push_back(xx);
        step();
        chk("bub_pre_rf0", wb_to_rf_bus[40:0], xx[40:0]);
        stall = 6'b010000;
        step();
        chk("bub_rf", wb_to_rf_bus, 0);
        yy = ln(32'h00000300, 4'hF, 5'd8, 32'h88);
        stall = 6'b000000;
        mem_to_wb_bus = {73'd0, yy};
        exp_q.push_back(yy);
        step();
        stall = 6'b110000;
        mem_to_wb_bus = '0;
        exp_q.push_back(yy);
        step();
        chk("hold_rf0", wb_to_rf_bus[40:0], yy[40:0]);
        stall = 6'b000000;
        step();
        chk("hold_release_rf", wb_to_rf_bus, 0);
        drain("hold_drain", 10);

        // Partial strobe on lane 1
        zz = ln(32'h00000400, 4'b0011, 5'd9, 32'hCAFEBABE);
        mem_to_wb_bus = {zz, 73'd0};
        exp_q.push_back(zz);
        step();
        chk("part_rf1", wb_to_rf_bus[81:41], {4'b0011, 5'd9, 32'hCAFEBABE});
        chk("part_rf0", wb_to_rf_bus[40:0], 0);
        mem_to_wb_bus = '0;
        drain("part_drain", 6);

        // Back-pressure: 10 full bundles, bench answers wb_stallreq with bubbles
        idx = 0;
        first_req = -1;
        req_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (wb_stallreq) begin
                req_cycles++;
                if (first_req < 0) first_req = idx;
                stall = 6'b010000;
            end else begin
                stall = 6'b000000;
                if (idx < 10) begin
                    a0 = ln(32'h1000 + 32'(idx * 8), 4'hF, 5'(idx + 1), 32'h1000 + 32'(idx * 8));
                    a1 = ln(32'h1004 + 32'(idx * 8), 4'hF, 5'(idx + 16), 32'h1004 + 32'(idx * 8));
                    mem_to_wb_bus = {a1, a0};
                    exp_q.push_back(a0);
                    exp_q.push_back(a1);
                    idx++;
                end else begin
                    mem_to_wb_bus = '0;
                end
            end
            step();
        end
        stall = 6'b000000;
        chk("bp_all_sent", idx, 10);
        chk("bp_first_req", first_req, 5);
        chk("bp_req_cycles", req_cycles, 6);
        drain("bp_drain", 30);

        // Reset mid-stream with 3 entries queued
        a0 = ln(32'h500, 4'hF, 5'd1, 32'h50);
        a1 = ln(32'h504, 4'hF, 5'd2, 32'h54);
        b0 = ln(32'h508, 4'hF, 5'd3, 32'h58);
        b1 = ln(32'h50C, 4'hF, 5'd4, 32'h5C);
        mem_to_wb_bus = {a1, a0};
        exp_q.push_back(a0);
        exp_q.push_back(a1);
        step();
        mem_to_wb_bus = {b1, b0};
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        step();
        mem_to_wb_bus = {73'd0, ln(32'h510, 4'hF, 5'd1, 32'h11)};
        step();
        chk("mid_first_pop", exp_q.size(), 3);
        resetn = 1'b0;
        #1;
        chk("mrst_rf", wb_to_rf_bus, 0);
        chk("mrst_req", wb_stallreq, 0);
        chk("mrst_pc", debug_wb_pc, 0);
        chk("mrst_wen", debug_wb_rf_wen, 0);
        chk("mrst_wnum", debug_wb_rf_wnum, 0);
        chk("mrst_wdata", debug_wb_rf_wdata, 0);
        exp_q.delete();
        mem_to_wb_bus = '0;
        step();
        resetn = 1'b1;
        nb = ln(32'h600, 4'hF, 5'd2, 32'h66);
        mem_to_wb_bus = {73'd0, nb};
        exp_q.push_back(nb);
        step();
        chk("post_rst_rf0", wb_to_rf_bus[40:0], nb[40:0]);
        mem_to_wb_bus = '0;
        drain("post_rst_drain", 6);
        for (int i = 0; i < 4; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
